alu_exec_unit: RTL and testbench

- Execution unit that consumes the 4-bit ALU control code produced by the ALU control decoder, plus two operands, and returns a registered result.
- Sits in the EX stage of the rhythm-game RISC-V core.
- Single-cycle ops complete in 1 cycle. mul/div/rem run on an iterative multiply/divide engine behind a valid/ready handshake; the pipeline stalls on ready=0.

---
 rtl/alu_exec_pkg.sv | 41 ++++
 rtl/mdu_iter.sv | 115 +++++++++++
 rtl/alu_exec_unit.sv | 112 +++++++++++
 tb/tb_alu_exec_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared control codes, MDU state/op types and helpers for the EX-stage ALU.
// ALU_FAST_MUL_EN moves mul from the iterative engine to a single-cycle product.
package alu_exec_pkg;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SLL  = 4'b0011;
  localparam logic [3:0] CTRL_SLT  = 4'b0100;
  localparam logic [3:0] CTRL_SLTU = 4'b0101;
  localparam logic [3:0] CTRL_BEQ  = 4'b0110;
  localparam logic [3:0] CTRL_XOR  = 4'b0111;
  localparam logic [3:0] CTRL_SRL  = 4'b1000;
  localparam logic [3:0] CTRL_JAL  = 4'b1001;
  localparam logic [3:0] CTRL_SRA  = 4'b1010;
  localparam logic [3:0] CTRL_REM  = 4'b1011;
  localparam logic [3:0] CTRL_NOP  = 4'b1100;
  localparam logic [3:0] CTRL_DIV  = 4'b1101;
  localparam logic [3:0] CTRL_MUL  = 4'b1110;
  localparam logic [3:0] CTRL_BNEQ = 4'b1111;

  typedef enum logic [1:0] {IDLE, ITER, FIX} mdu_state_e;
  typedef enum logic [1:0] {MDU_MUL, MDU_DIV, MDU_REM} mdu_op_e;

  function automatic logic is_multicycle(input logic [3:0] ctrl);
`ifdef ALU_FAST_MUL_EN
    return (ctrl == CTRL_DIV) || (ctrl == CTRL_REM);
`else
    return (ctrl == CTRL_DIV) || (ctrl == CTRL_REM) || (ctrl == CTRL_MUL);
`endif
  endfunction

  function automatic mdu_op_e to_mdu_op(input logic [3:0] ctrl);
    case (ctrl)
      CTRL_DIV: return MDU_DIV;
      CTRL_REM: return MDU_REM;
      default:  return MDU_MUL;
    endcase
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply / restoring-divide engine: WIDTH ITER cycles then one FIX cycle.
// state | meaning
// IDLE  | waiting for start, operands latched on start
// ITER  | one shift-add or restore-divide step per cycle, cnt_q WIDTH-1 down to 0
// FIX   | sign correction and special cases; results valid while done=1
import alu_exec_pkg::*;

module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  mdu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  mdu_op_e          op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             neg_q;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
  logic [WIDTH:0]   shifted, diff;
  logic             dz, ovf;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ITER;
      ITER:    if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvsr_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      op_q     <= MDU_MUL;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
    end else if (state_q == IDLE && start) begin
      cnt_q    <= CW'(WIDTH - 1);
      op_q     <= op;
      a_q      <= a;
      b_q      <= b;
      neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
      acc_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
      rem_q    <= '0;
      quo_q    <= a[WIDTH-1] ? -a : a;
      dvsr_q   <= b[WIDTH-1] ? -b : b;
    end else if (state_q == ITER) begin
      cnt_q <= cnt_q - CW'(1);
      if (op_q == MDU_MUL) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end else if (!diff[WIDTH]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Special cases override the magnitude datapath, so latency never changes.
  assign dz  = (b_q == '0);
  assign ovf = (a_q == MOST_NEG) && (b_q == '1);

  always_comb begin
    prod = acc_q;
    if (dz)         quot = '1;
    else if (ovf)   quot = a_q;
    else if (neg_q) quot = -quo_q;
    else            quot = quo_q;
    if (dz)                 rem = a_q;
    else if (ovf)           rem = '0;
    else if (a_q[WIDTH-1])  rem = -rem_q;
    else                    rem = rem_q;
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == FIX);

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle datapath, valid/ready handshake and output registers.
// Build option ALU_FAST_MUL_EN makes mul single-cycle; div/rem always use mdu_iter.
import alu_exec_pkg::*;

module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             valid_out,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             branch_taken
);

  logic             accept, multi, eq, br_now;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] diff, alu_res, mdu_res;
  logic             mdu_busy, mdu_done;
  logic [WIDTH-1:0] mdu_prod, mdu_quot, mdu_rem;
  logic             zero_pend;
  mdu_op_e          mop_pend;

  assign ready  = !mdu_busy;
  assign accept = valid_in && ready;
  assign multi  = is_multicycle(alu_ctrl);
  assign sh     = op_b[SHW-1:0];
  assign diff   = op_a - op_b;
  assign eq     = (diff == '0);
  assign br_now = (alu_ctrl == CTRL_BEQ) ? eq : (alu_ctrl == CTRL_BNEQ) ? !eq : 1'b0;

  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      CTRL_AND:  alu_res = op_a & op_b;
      CTRL_OR:   alu_res = op_a | op_b;
      CTRL_ADD:  alu_res = op_a + op_b;
      CTRL_SLL:  alu_res = op_a << sh;
      CTRL_SLT:  alu_res = WIDTH'($signed(op_a) < $signed(op_b));
      CTRL_SLTU: alu_res = WIDTH'(op_a < op_b);
      CTRL_BEQ:  alu_res = diff;
      CTRL_XOR:  alu_res = op_a ^ op_b;
      CTRL_SRL:  alu_res = op_a >> sh;
      CTRL_JAL:  alu_res = op_a + WIDTH'(4);
      CTRL_SRA:  alu_res = $signed(op_a) >>> sh;
      CTRL_BNEQ: alu_res = diff;
`ifdef ALU_FAST_MUL_EN
      CTRL_MUL:  alu_res = op_a * op_b;
`endif
      default:   alu_res = '0;
    endcase
  end

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk   (clk),
    .reset (reset),
    .start (accept && multi),
    .op    (to_mdu_op(alu_ctrl)),
    .a     (op_a),
    .b     (op_b),
    .busy  (mdu_busy),
    .done  (mdu_done),
    .prod  (mdu_prod),
    .quot  (mdu_quot),
    .rem   (mdu_rem)
  );

  always_comb begin
    case (mop_pend)
      MDU_DIV: mdu_res = mdu_quot;
      MDU_REM: mdu_res = mdu_rem;
      default: mdu_res = mdu_prod;
    endcase
  end

  // zero is captured at accept so later operand changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out    <= 1'b0;
      result       <= '0;
      zero         <= 1'b0;
      branch_taken <= 1'b0;
      zero_pend    <= 1'b0;
      mop_pend     <= MDU_MUL;
    end else begin
      valid_out <= 1'b0;
      if (accept && !multi) begin
        valid_out    <= 1'b1;
        result       <= alu_res;
        zero         <= eq;
        branch_taken <= br_now;
      end
      if (accept && multi) begin
        zero_pend <= eq;
        mop_pend  <= to_mdu_op(alu_ctrl);
      end
      if (mdu_done) begin
        valid_out    <= 1'b1;
        result       <= mdu_res;
        zero         <= zero_pend;
        branch_taken <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized ops vs a reference model.
module tb_alu_exec_unit;

  localparam int W = 32;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 2;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid_in = 1'b0;
  logic [3:0]   alu_ctrl = 4'h0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         ready, valid_out, zero, branch_taken;
  logic [W-1:0] result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .ready        (ready),
    .alu_ctrl     (alu_ctrl),
    .op_a         (op_a),
    .op_b         (op_b),
    .valid_out    (valid_out),
    .result       (result),
    .zero         (zero),
    .branch_taken (branch_taken)
  );

  function automatic logic [W-1:0] ref_result(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q;
    logic [63:0] p;
    int s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = int'(b[4:0]);
    case (c)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a << s;
      4'd4:  return (sa < sb) ? 1 : 0;
      4'd5:  return (a < b) ? 1 : 0;
      4'd6:  return a - b;
      4'd7:  return a ^ b;
      4'd8:  return a >> s;
      4'd9:  return a + 4;
      4'd10: begin q = sa >>> s; return q[W-1:0]; end
      4'd11: begin
        if (b == 0) return a;
        if (a == MINV && b == '1) return 0;
        q = sa % sb; return q[W-1:0];
      end
      4'd13: begin
        if (b == 0) return '1;
        if (a == MINV && b == '1) return a;
        q = sa / sb; return q[W-1:0];
      end
      4'd14: begin p = {32'b0, a} * {32'b0, b}; return p[W-1:0]; end
      4'd15: return a - b;
      default: return 0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] c);
    if (c == 4'd11 || c == 4'd13) return W + 2;
    if (c == 4'd14) return MUL_LAT;
    return 1;
  endfunction

  // Issues one op when ready, scrambles inputs after accept, waits for valid_out.
  task automatic do_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic z, output logic br,
                       output int lat, output int nrdy);
    r = 'x; z = 1'bx; br = 1'bx; lat = -1; nrdy = 0;
    @(negedge clk);
    valid_in = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
    @(negedge clk);
    valid_in = 1'b0; alu_ctrl = 4'($urandom); op_a = $urandom; op_b = $urandom;
    for (int i = 1; i <= W + 8; i++) begin
      if (valid_out) begin
        lat = i; r = result; z = zero; br = branch_taken;
        break;
      end
      if (!ready) nrdy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tests++;
    if ({ready, valid_out, zero, branch_taken} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_flags: got rdy/vo/z/br=%b want 1000", {ready, valid_out, zero, branch_taken});
    end
    tests++;
    if (result !== '0) begin
      fails++;
      $display("FAIL reset_result: got %h want 0", result);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    valid_in = 1'b1; alu_ctrl = 4'b0010; op_a = 7; op_b = 5;
    @(negedge clk);
    tests++;
    if (!(valid_out === 1'b1 && result === 32'd12 && ready === 1'b1)) begin
      fails++;
      $display("FAIL b2b_add: got vo=%b res=%h rdy=%b want vo=1 res=0000000c rdy=1", valid_out, result, ready);
    end
    alu_ctrl = 4'b0110; op_a = 5; op_b = 5;
    @(negedge clk);
    valid_in = 1'b0;
    tests++;
    if (!(valid_out === 1'b1 && result === '0 && zero === 1'b1 && branch_taken === 1'b1 && ready === 1'b1)) begin
      fails++;
      $display("FAIL b2b_beq: got vo=%b res=%h z=%b br=%b rdy=%b want 1 0 1 1 1",
               valid_out, result, zero, branch_taken, ready);
    end
    @(negedge clk);
    tests++;
    if (valid_out !== 1'b0) begin
      fails++;
      $display("FAIL b2b_pulse: got vo=%b want 0", valid_out);
    end
  endtask

  task automatic test_bneq_sra;
    logic [W-1:0] r; logic z, br; int lat, nr;
    do_op(4'b1111, 3, 4, r, z, br, lat, nr);
    tests++;
    if (!(r === 32'hFFFFFFFF && z === 1'b0 && br === 1'b1 && lat == 1)) begin
      fails++;
      $display("FAIL bneq: got res=%h z=%b br=%b lat=%0d want ffffffff 0 1 1", r, z, br, lat);
    end
    do_op(4'b1010, 32'h80000000, 4, r, z, br, lat, nr);
    tests++;
    if (!(r === 32'hF8000000 && br === 1'b0 && lat == 1)) begin
      fails++;
      $display("FAIL sra: got res=%h br=%b lat=%0d want f8000000 0 1", r, br, lat);
    end
  endtask

  task automatic test_mul;
    logic [W-1:0] r; logic z, br; int lat, nr;
    do_op(4'b1110, 32'hFFFFFFFF, 3, r, z, br, lat, nr);
    tests++;
    if (!(r === 32'hFFFFFFFD && lat == MUL_LAT && nr == MUL_LAT - 1)) begin
      fails++;
      $display("FAIL mul: got res=%h lat=%0d busy=%0d want fffffffd lat=%0d busy=%0d",
               r, lat, nr, MUL_LAT, MUL_LAT - 1);
    end
  endtask

  task automatic test_div_special;
    logic [W-1:0] r; logic z, br; int lat, nr;
    logic [3:0]   c [6] = '{4'b1101, 4'b1011, 4'b1101, 4'b1011, 4'b1101, 4'b1011};
    logic [W-1:0] a [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd9, 32'd9, 32'h80000000, 32'h80000000};
    logic [W-1:0] b [6] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [W-1:0] e [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd9, 32'h80000000, 32'd0};
    for (int k = 0; k < 6; k++) begin
      do_op(c[k], a[k], b[k], r, z, br, lat, nr);
      tests++;
      if (!(r === e[k] && lat == W + 2 && nr == W + 1)) begin
        fails++;
        $display("FAIL divspec_%0d: got res=%h lat=%0d busy=%0d want %h lat=%0d busy=%0d",
                 k, r, lat, nr, e[k], W + 2, W + 1);
      end
    end
  endtask

  task automatic test_reset_mid_div;
    logic [W-1:0] r; logic z, br; int lat, nr, nvo;
    @(negedge clk);
    valid_in = 1'b1; alu_ctrl = 4'b1101; op_a = 100; op_b = 7;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (9) @(negedge clk);
    tests++;
    if (ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_busy: got rdy=%b want 0", ready);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if (!(valid_out === 1'b0 && result === '0 && ready === 1'b1)) begin
      fails++;
      $display("FAIL rst_mid_state: got vo=%b res=%h rdy=%b want 0 0 1", valid_out, result, ready);
    end
    nvo = 0;
    for (int i = 0; i < W + 8; i++) begin
      if (valid_out) nvo++;
      @(negedge clk);
    end
    tests++;
    if (nvo != 0) begin
      fails++;
      $display("FAIL rst_mid_novo: got %0d valid_out pulses want 0", nvo);
    end
    do_op(4'b0010, 1, 1, r, z, br, lat, nr);
    tests++;
    if (!(r === 32'd2 && lat == 1)) begin
      fails++;
      $display("FAIL rst_mid_add: got res=%h lat=%0d want 00000002 1", r, lat);
    end
  endtask

  task automatic test_ignore_during_div;
    int nvo, lat;
    logic [W-1:0] r;
    nvo = 0; lat = -1; r = 'x;
    @(negedge clk);
    valid_in = 1'b1; alu_ctrl = 4'b1101; op_a = 100; op_b = 7;
    @(negedge clk);
    valid_in = 1'b0;
    for (int i = 1; i <= W + 8; i++) begin
      if (valid_out) begin
        nvo++;
        if (lat < 0) begin lat = i; r = result; end
      end
      if (i == 5) begin valid_in = 1'b1; alu_ctrl = 4'b0010; op_a = 1; op_b = 1; end
      if (i == 6) valid_in = 1'b0;
      @(negedge clk);
    end
    tests++;
    if (!(nvo == 1 && lat == W + 2 && r === 32'd14)) begin
      fails++;
      $display("FAIL ignore_busy: got pulses=%0d lat=%0d res=%h want 1 %0d 0000000e", nvo, lat, r, W + 2);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, r, er; logic [3:0] c; logic z, br, ez, ebr; int lat, nr, sel;
    for (int n = 0; n < 60; n++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 0;
      else if (sel == 1) begin a = MINV; b = '1; end
      else if (sel == 2) b = a;
      else if (sel == 3) begin a = $urandom_range(0, 20); b = $urandom_range(0, 20); end
      do_op(c, a, b, r, z, br, lat, nr);
      er  = ref_result(c, a, b);
      ez  = (a == b);
      ebr = (c == 4'd6) ? ez : (c == 4'd15) ? !ez : 1'b0;
      tests++;
      if (r !== er) begin
        fails++;
        $display("FAIL rand_res[%0d] ctrl=%h a=%h b=%h: got %h want %h", n, c, a, b, r, er);
      end
      tests++;
      if ({z, br} !== {ez, ebr}) begin
        fails++;
        $display("FAIL rand_flags[%0d] ctrl=%h: got z/br=%b%b want %b%b", n, c, z, br, ez, ebr);
      end
      tests++;
      if (lat != ref_latency(c)) begin
        fails++;
        $display("FAIL rand_lat[%0d] ctrl=%h: got %0d want %0d", n, c, lat, ref_latency(c));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_bneq_sra();
    test_mul();
    test_div_special();
    test_reset_mid_div();
    test_ignore_during_div();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
